// File: rtl/sample_mem_arbiter_if.sv
// sample_mem_arbiter_if: acquisition writer, readout requester and RAM-side signals of the sample memory arbiter
interface sample_mem_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
        output rd_ack, rd_valid, rd_data, rd_err, mem_addr, mem_wdata, mem_we
    );
    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
        input  rd_ack, rd_valid, rd_data, rd_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/sample_mem_arbiter.sv
// sample_mem_arbiter: shares the single-port sample RAM, acquisition writes always win, readout takes idle slots
module sample_mem_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 51200,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    sample_mem_arbiter_if.slave  bus,
    input  logic                 flags_clr,
    output logic                 wr_drop,
    output logic                 rd_starved
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CW-1:0] CMAX = CW'(STARVE_MAX);

    logic [1:0]         state;
    logic               err0;
    logic [MEM_LAT-1:0] v_sr;
    logic [MEM_LAT-1:0] e_sr;
    logic [CW-1:0]      starve_cnt;
    logic               wr_ok;
    logic               rd_ok;
    logic               blocked;
    logic               drop_set;
    logic               starve_set;

    assign wr_ok        = {1'b0, bus.wr_addr} < LIMIT;
    assign rd_ok        = {1'b0, bus.rd_addr} < LIMIT;
    assign bus.rd_ack   = !reset && !bus.wr_req && bus.rd_req;
    assign blocked      = bus.rd_req && bus.wr_req;
    assign drop_set     = bus.wr_req && !wr_ok;
    assign starve_set   = blocked && starve_cnt >= CMAX - CW'(1);
    assign bus.rd_valid = v_sr[MEM_LAT-1];
    assign bus.rd_err   = e_sr[MEM_LAT-1];
    assign bus.rd_data  = (bus.rd_valid && !bus.rd_err) ? bus.mem_rdata : '0;

    // state==S_READ is the first stage of the read-return pipeline; v_sr/e_sr add MEM_LAT more
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            err0          <= 1'b0;
            v_sr          <= '0;
            e_sr          <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            starve_cnt    <= '0;
            wr_drop       <= 1'b0;
            rd_starved    <= 1'b0;
        end else begin
            state   <= bus.wr_req ? S_WRITE : bus.rd_req ? S_READ : S_IDLE;
            err0    <= bus.rd_ack && !rd_ok;
            v_sr[0] <= state == S_READ;
            e_sr[0] <= err0;
            for (int i = 1; i < MEM_LAT; i++) begin
                v_sr[i] <= v_sr[i-1];
                e_sr[i] <= e_sr[i-1];
            end
            bus.mem_we <= bus.wr_req && wr_ok;
            if (bus.wr_req ? wr_ok : bus.rd_req && rd_ok)
                bus.mem_addr <= bus.wr_req ? bus.wr_addr : bus.rd_addr;
            if (bus.wr_req && wr_ok)
                bus.mem_wdata <= bus.wr_data;
            starve_cnt <= !blocked ? '0 : starve_cnt == CMAX ? CMAX : starve_cnt + CW'(1);
            wr_drop    <= drop_set || (wr_drop && !flags_clr);
            rd_starved <= starve_set || (rd_starved && !flags_clr);
        end
    end
endmodule

// File: tb/tb_sample_mem_arbiter.sv
// tb_sample_mem_arbiter: directed scoreboard bench for sample_mem_arbiter with a behavioural RAM
module tb_sample_mem_arbiter;
    localparam int DEPTH = 51200;

    typedef struct {
        int         due;
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        flags_clr;
    logic        wr_drop;
    logic        rd_starved;
    int          checks;
    int          errors;
    int          cyc;
    int          nvalid;
    logic [16:0] ea;
    logic [7:0]  ed;
    logic [7:0]  ram     [0:DEPTH-1];
    logic [7:0]  exp_mem [0:DEPTH-1];
    exp_t        sb[$];
    exp_t        mon_e;

    sample_mem_arbiter_if #(.ADDR_W(17), .DATA_W(8)) bus ();

    sample_mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .flags_clr  (flags_clr),
        .wr_drop    (wr_drop),
        .rd_starved (rd_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM macro with one cycle read latency, read-before-write
    always @(posedge clk) begin
        bus.mem_rdata <= (bus.mem_addr < 17'(DEPTH)) ? ram[bus.mem_addr] : 8'h00;
        if (bus.mem_we === 1'b1 && bus.mem_addr < 17'(DEPTH))
            ram[bus.mem_addr] = bus.mem_wdata;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no end, expected finish");
        $fatal(1);
    end

    function automatic logic [7:0] pat(int i);
        return 8'(i * 3 + 45);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            nvalid++;
            if (sb.size() == 0)
                chk("rd_unexpected", 32'(bus.rd_valid), 32'd0);
            else begin
                mon_e = sb.pop_front();
                chk("rd_cycle", 32'(cyc), 32'(mon_e.due));
                chk("rd_err", 32'(bus.rd_err), 32'(mon_e.err));
                chk("rd_data", 32'(bus.rd_data), 32'(mon_e.data));
            end
        end else if (sb.size() != 0 && cyc >= sb[0].due) begin
            mon_e = sb.pop_front();
            chk("rd_missing", 32'(bus.rd_valid), 32'd1);
        end
    end

    task automatic step(input logic wr, input logic [16:0] wa, input logic [7:0] wd,
                        input logic rr, input logic [16:0] ra);
        exp_t x;
        logic acc;
        logic ewe;
        bus.wr_req  = wr;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_req  = rr;
        bus.rd_addr = ra;
        acc = rr && !wr;
        ewe = wr && wa < 17'(DEPTH);
        if (acc) begin
            x.due  = cyc + 2;
            x.err  = ra >= 17'(DEPTH);
            x.data = 8'h00;
            if (!x.err) x.data = exp_mem[ra];
            sb.push_back(x);
        end
        if (ewe) begin
            exp_mem[wa] = wd;
            ea = wa;
            ed = wd;
        end else if (acc && ra < 17'(DEPTH))
            ea = ra;
        @(negedge clk);
        chk("rd_ack", 32'(bus.rd_ack), 32'(acc));
        @(posedge clk);
        #1;
        chk("mem_we", 32'(bus.mem_we), 32'(ewe));
        chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(ed));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 17'd0, 8'h00, 1'b0, 17'd0);
    endtask

    task automatic check_zero();
        chk("z_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("z_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("z_mem_we", 32'(bus.mem_we), 32'd0);
        chk("z_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("z_rd_err", 32'(bus.rd_err), 32'd0);
        chk("z_rd_data", 32'(bus.rd_data), 32'd0);
        chk("z_rd_ack", 32'(bus.rd_ack), 32'd0);
        chk("z_wr_drop", 32'(wr_drop), 32'd0);
        chk("z_rd_starved", 32'(rd_starved), 32'd0);
    endtask

    initial begin
        int base;
        int idx;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = pat(i);
            exp_mem[i] = pat(i);
        end
        reset       = 1'b1;
        flags_clr   = 1'b0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ea = '0;
        ed = '0;
        check_zero();

        // single read of RAM[5]
        step(1'b0, 17'd0, 8'h00, 1'b1, 17'd5);
        idle(3);

        // write and read collide on address 7
        step(1'b1, 17'd7, 8'hA5, 1'b1, 17'd7);
        step(1'b0, 17'd0, 8'h00, 1'b1, 17'd7);
        idle(3);

        // read burst 0..9 interrupted by one write
        base = nvalid;
        idx = 0;
        for (int c = 0; c < 11; c++) begin
            if (c == 5)
                step(1'b1, 17'd300, 8'h77, 1'b1, 17'(idx));
            else begin
                step(1'b0, 17'd0, 8'h00, 1'b1, 17'(idx));
                idx++;
            end
        end
        idle(3);
        chk("burst_count", 32'(nvalid - base), 32'd10);

        // range boundaries and sticky drop flag
        step(1'b1, 17'd51200, 8'h11, 1'b0, 17'd0);
        chk("wr_drop_set", 32'(wr_drop), 32'd1);
        step(1'b1, 17'd51199, 8'h22, 1'b0, 17'd0);
        step(1'b0, 17'd0, 8'h00, 1'b1, 17'd60000);
        step(1'b0, 17'd0, 8'h00, 1'b1, 17'd51200);
        step(1'b0, 17'd0, 8'h00, 1'b1, 17'd51199);
        idle(3);
        flags_clr = 1'b1;
        step(1'b1, 17'd51200, 8'h33, 1'b0, 17'd0);
        chk("wr_drop_set_wins", 32'(wr_drop), 32'd1);
        idle(1);
        chk("wr_drop_cleared", 32'(wr_drop), 32'd0);
        flags_clr = 1'b0;

        // starvation: 1024 blocked cycles sets the flag
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, 17'(1000 + i), 8'(i), 1'b1, 17'd1000);
            chk("starve_1024", 32'(rd_starved), 32'(i >= 1023));
        end
        step(1'b0, 17'd0, 8'h00, 1'b1, 17'd1000);
        chk("starve_sticky", 32'(rd_starved), 32'd1);
        flags_clr = 1'b1;
        idle(1);
        flags_clr = 1'b0;
        chk("starve_cleared", 32'(rd_starved), 32'd0);
        for (int i = 0; i < 1023; i++) begin
            step(1'b1, 17'(3000 + i), 8'(i + 1), 1'b1, 17'd1001);
            chk("starve_1023", 32'(rd_starved), 32'd0);
        end
        step(1'b0, 17'd0, 8'h00, 1'b1, 17'd1001);
        chk("starve_after_ack", 32'(rd_starved), 32'd0);
        idle(3);
        chk("starve_stays", 32'(rd_starved), 32'd0);

        // reset one cycle after an accepted read
        step(1'b1, 17'd60000, 8'h00, 1'b0, 17'd0);
        chk("wr_drop_pre_reset", 32'(wr_drop), 32'd1);
        step(1'b0, 17'd0, 8'h00, 1'b1, 17'd9);
        reset       = 1'b1;
        bus.rd_addr = 17'd9;
        bus.rd_req  = 1'b1;
        @(negedge clk);
        chk("rd_ack_in_reset", 32'(bus.rd_ack), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        bus.rd_req = 1'b0;
        ea = '0;
        ed = '0;
        check_zero();
        idle(4);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
